// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - payload width and field offsets for the packed AXI-Stream beat
package axi_stream_pkg;

  // Packed beat layout, LSB first: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
  localparam int OFF_DATA = 0;

  function automatic int payload_width(input int bw, input int id, input int dest, input int user);
    return 8*bw + 2*bw + 1 + id + dest + user;
  endfunction

  function automatic int off_strb(input int bw);
    return 8*bw;
  endfunction

  function automatic int off_keep(input int bw);
    return 9*bw;
  endfunction

  function automatic int off_last(input int bw);
    return 10*bw;
  endfunction

  function automatic int off_id(input int bw);
    return 10*bw + 1;
  endfunction

  function automatic int off_dest(input int bw, input int id);
    return 10*bw + 1 + id;
  endfunction

  function automatic int off_user(input int bw, input int id, input int dest);
    return 10*bw + 1 + id + dest;
  endfunction

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// rtl/axi_stream_fifo_mem.sv - simple dual-port payload RAM, synchronous write and read
module axi_stream_fifo_mem #(
  parameter int width      = 8,
  parameter int entries    = 1,
  parameter int addr_width = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0]      wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [width-1:0]      rdata
);

  logic [width-1:0] mem [entries];

  // Write port and registered read port; a read of the address written on the same edge returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_stream_sync_fifo.sv
// rtl/axi_stream_sync_fifo.sv - single-clock AXI-Stream FIFO with registered master outputs
module axi_stream_sync_fifo
  import axi_stream_pkg::*;
#(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int depth      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [8*byte_width-1:0]   s_tdata,
  input  logic [byte_width-1:0]     s_tstrb,
  input  logic [byte_width-1:0]     s_tkeep,
  input  logic                      s_tlast,
  input  logic [id_width-1:0]       s_tid,
  input  logic [dest_width-1:0]     s_tdest,
  input  logic [user_width-1:0]     s_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [8*byte_width-1:0]   m_tdata,
  output logic [byte_width-1:0]     m_tstrb,
  output logic [byte_width-1:0]     m_tkeep,
  output logic                      m_tlast,
  output logic [id_width-1:0]       m_tid,
  output logic [dest_width-1:0]     m_tdest,
  output logic [user_width-1:0]     m_tuser,
  output logic [$clog2(depth):0]    count,
  output logic [$clog2(depth):0]    pkt_count
);

  localparam int DW     = 8*byte_width;
  localparam int PW     = payload_width(byte_width, id_width, dest_width, user_width);
  localparam int CW     = $clog2(depth) + 1;
  localparam int AW     = $clog2(depth);
  localparam int O_STRB = off_strb(byte_width);
  localparam int O_KEEP = off_keep(byte_width);
  localparam int O_LAST = off_last(byte_width);
  localparam int O_ID   = off_id(byte_width);
  localparam int O_DEST = off_dest(byte_width, id_width);
  localparam int O_USER = off_user(byte_width, id_width, dest_width);
  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [AW-1:0] PTR_LAST = AW'(depth - 2);

  // The master register holds one beat, so the RAM only needs depth-1 entries.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic [PW-1:0] s_payload, mem_rdata;
  logic [PW-1:0] out_payload_q, out_payload_d;
  logic          out_valid_q, out_valid_d;
  logic          s_tready_q, s_tready_d;
  logic          head_stale_q, head_stale_d;
  logic [CW-1:0] count_q, count_d, pkt_count_q, pkt_count_d, mem_cnt_q, mem_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          push, pop, out_free, load_mem, bypass, mem_wr;

  // Pack the slave beat into one vector for storage.
  always_comb begin
    s_payload                          = '0;
    s_payload[OFF_DATA +: DW]          = s_tdata;
    s_payload[O_STRB +: byte_width]    = s_tstrb;
    s_payload[O_KEEP +: byte_width]    = s_tkeep;
    s_payload[O_LAST]                  = s_tlast;
    s_payload[O_ID +: id_width]        = s_tid;
    s_payload[O_DEST +: dest_width]    = s_tdest;
    s_payload[O_USER +: user_width]    = s_tuser;
  end

  // Next state: an empty FIFO bypasses the RAM into the master register; a head freshly
  // written on the previous edge is not yet visible on the RAM read port and waits one cycle.
  always_comb begin
    push     = s_tvalid && s_tready_q;
    pop      = out_valid_q && m_tready;
    out_free = !out_valid_q || pop;
    load_mem = out_free && (mem_cnt_q != '0) && !head_stale_q;
    bypass   = out_free && push && (mem_cnt_q == '0);
    mem_wr   = push && !bypass;

    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    if (out_free) begin
      out_valid_d = load_mem || bypass;
      if (load_mem) begin
        out_payload_d = mem_rdata;
      end else if (bypass) begin
        out_payload_d = s_payload;
      end
    end

    rd_ptr_d     = load_mem ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d     = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    mem_cnt_d    = mem_cnt_q + CW'(mem_wr) - CW'(load_mem);
    head_stale_d = mem_wr && ((mem_cnt_q == '0) || ((mem_cnt_q == CW'(1)) && load_mem));
    count_d      = count_q + CW'(push) - CW'(pop);
    pkt_count_d  = pkt_count_q + CW'(push && s_tlast) - CW'(pop && out_payload_q[O_LAST]);
    s_tready_d   = count_d < DEPTH_C;
  end

  // State registers with synchronous reset that drops any buffered beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_payload_q <= '0;
      out_valid_q   <= 1'b0;
      s_tready_q    <= 1'b0;
      head_stale_q  <= 1'b0;
      count_q       <= '0;
      pkt_count_q   <= '0;
      mem_cnt_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      out_payload_q <= out_payload_d;
      out_valid_q   <= out_valid_d;
      s_tready_q    <= s_tready_d;
      head_stale_q  <= head_stale_d;
      count_q       <= count_d;
      pkt_count_q   <= pkt_count_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  axi_stream_fifo_mem #(
    .width      (PW),
    .entries    (depth - 1),
    .addr_width (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_wr),
    .waddr (wr_ptr_q),
    .wdata (s_payload),
    .raddr (rd_ptr_d),
    .rdata (mem_rdata)
  );

  assign s_tready  = s_tready_q;
  assign m_tvalid  = out_valid_q;
  assign m_tdata   = out_payload_q[OFF_DATA +: DW];
  assign m_tstrb   = out_payload_q[O_STRB +: byte_width];
  assign m_tkeep   = out_payload_q[O_KEEP +: byte_width];
  assign m_tlast   = out_payload_q[O_LAST];
  assign m_tid     = out_payload_q[O_ID +: id_width];
  assign m_tdest   = out_payload_q[O_DEST +: dest_width];
  assign m_tuser   = out_payload_q[O_USER +: user_width];
  assign count     = count_q;
  assign pkt_count = pkt_count_q;

endmodule
